// File: rtl/mult_div_unit.sv
// Signed 32-bit multiply (radix-2 Booth) and divide (restoring) unit for MIPS HI/LO.
// Define DIVZERO_EXCP_EN to trap divide-by-zero through DZ / div_zero instead of completing.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        mult_start,
    input  logic        div_start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MULT = 3'd1;
    localparam logic [2:0] DIV  = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
`ifdef DIVZERO_EXCP_EN
    localparam logic [2:0] DZ   = 3'd4;
`endif
    localparam logic [2:0] DONE = 3'd5;

    logic [2:0]  state;
    logic [5:0]  count;

    // Booth datapath: {acc, mplier, qm1} shifts right arithmetically each step.
    logic [32:0] acc;
    logic [32:0] mcand;
    logic [31:0] mplier;
    logic        qm1;
    logic [32:0] boothSum;

    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] divisor;
    logic        dividendNeg;
    logic        divisorNeg;
    logic        divByZero;
    logic [31:0] origA;

    logic [31:0] absA;
    logic [31:0] absB;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] fixHi;
    logic [31:0] fixLo;

    assign absA    = op_a[31] ? -op_a : op_a;
    assign absB    = op_b[31] ? -op_b : op_b;
    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, divisor};
    assign fits    = shifted >= {1'b0, divisor};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        boothSum = acc;
        case ({mplier[0], qm1})
            2'b01:   boothSum = acc + mcand;
            2'b10:   boothSum = acc - mcand;
            default: ;
        endcase
    end

    always_comb begin
        fixLo = (dividendNeg ^ divisorNeg) ? -quo : quo;
        fixHi = dividendNeg ? -rem : rem;
        if (divByZero) begin
            fixLo = '1;
            fixHi = origA;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
`ifdef DIVZERO_EXCP_EN
    assign div_zero = (state == DZ);
`else
    assign div_zero = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: datapath registers are reset too; they are few and it keeps X out of hi/lo.
            state       <= IDLE;
            count       <= '0;
            hi          <= '0;
            lo          <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            qm1         <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            divisor     <= '0;
            dividendNeg <= 1'b0;
            divisorNeg  <= 1'b0;
            divByZero   <= 1'b0;
            origA       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (mult_start) begin
                        acc    <= '0;
                        mcand  <= {op_a[31], op_a};
                        mplier <= op_b;
                        qm1    <= 1'b0;
                        state  <= MULT;
                    end else if (div_start) begin
                        rem         <= '0;
                        quo         <= absA;
                        divisor     <= absB;
                        dividendNeg <= op_a[31];
                        divisorNeg  <= op_b[31];
                        divByZero   <= (op_b == '0);
                        origA       <= op_a;
`ifdef DIVZERO_EXCP_EN
                        state       <= (op_b == '0) ? DZ : DIV;
`else
                        state       <= DIV;
`endif
                    end
                end
                MULT: begin
                    if (count == 6'd32) begin
                        hi    <= acc[31:0];
                        lo    <= mplier;
                        state <= DONE;
                    end else begin
                        acc    <= {boothSum[32], boothSum[32:1]};
                        mplier <= {boothSum[0], mplier[31:1]};
                        qm1    <= mplier[0];
                        count  <= count + 6'd1;
                    end
                end
                DIV: begin
                    if (count == 6'd32) begin
                        state <= FIX;
                    end else begin
                        rem   <= fits ? diff[31:0] : shifted[31:0];
                        quo   <= {quo[30:0], fits};
                        count <= count + 6'd1;
                    end
                end
                FIX: begin
                    hi    <= fixHi;
                    lo    <= fixLo;
                    state <= DONE;
                end
`ifdef DIVZERO_EXCP_EN
                DZ:      state <= IDLE;
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written corner
// sequences and randomized operations against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_start;
    logic        div_start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int total = 0;
    int bad   = 0;

    // Expected architectural HI/LO contents, maintained from the model only.
    logic [31:0] curHi = '0;
    logic [31:0] curLo = '0;

    typedef struct {
        bit          isMult;
        bit          both;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eHi;
        logic [31:0] eLo;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    mult_div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .op_a       (op_a),
        .op_b       (op_b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // {hi, lo} from plain signed arithmetic; SV / and % truncate toward zero.
    function automatic logic [63:0] refResult(input bit isMult, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        if (isMult) return 64'(sa * sb);
        if (b == '0) return {a, 32'hFFFF_FFFF};
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    task automatic runOp(input string tag, input bit isMult, input bit both,
                         input logic [31:0] a, input logic [31:0] b, input bit noise,
                         input logic [63:0] exp, input int expLat);
        int lat     = -1;
        bit busyBad = 1'b0;
        bit holdBad = 1'b0;
        bit zSeen   = 1'b0;
        @(negedge clk);
        mult_start = isMult | both;
        div_start  = !isMult | both;
        op_a = a;
        op_b = b;
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        for (int n = 0; n < 100; n++) begin
            mult_start = noise && (n == 5);
            div_start  = noise && (n == 5);
            if (done) begin
                lat = n;
                break;
            end
            if (!busy) busyBad = 1'b1;
            if (div_zero) zSeen = 1'b1;
            if ({hi, lo} !== {curHi, curLo}) holdBad = 1'b1;
            @(posedge clk);
            #1;
        end
        mult_start = 1'b0;
        div_start  = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(expLat));
        check({tag, " result"}, {hi, lo}, exp);
        check({tag, " busy in done"}, 64'(busy), 64'd1);
        check({tag, " busy throughout"}, 64'(busyBad), 64'd0);
        check({tag, " hi/lo held"}, 64'(holdBad), 64'd0);
        check({tag, " no div_zero"}, 64'(zSeen), 64'd0);
        {curHi, curLo} = exp;
        @(posedge clk);
        #1;
        check({tag, " idle after done"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        #1;
        check("reset outputs", {hi, lo}, 64'd0);
        check("reset flags", {61'd0, busy, done, div_zero}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        vecs.push_back('{1, 0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33});
        vecs.push_back('{1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33});
        vecs.push_back('{0, 0, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 34});
        vecs.push_back('{0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34});
        vecs.push_back('{1, 1, 32'd6,          32'd7,          32'd0,          32'd42,          33});
        vecs.push_back('{1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,          32'd1,           33});
        vecs.push_back('{0, 0, 32'd7,          32'hFFFF_FFFE, 32'd1,          32'hFFFF_FFFD, 34});
        vecs.push_back('{0, 0, 32'd3,          32'd10,         32'd3,          32'd0,           34});
`ifndef DIVZERO_EXCP_EN
        vecs.push_back('{0, 0, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF, 34});
`endif
        foreach (vecs[i])
            runOp($sformatf("vec%0d", i), vecs[i].isMult, vecs[i].both, vecs[i].a, vecs[i].b,
                  1'b0, {vecs[i].eHi, vecs[i].eLo}, vecs[i].lat);

`ifdef DIVZERO_EXCP_EN
        @(negedge clk);
        div_start = 1'b1;
        op_a = 32'd5;
        op_b = 32'd0;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        check("dz pulse", {61'd0, div_zero, done, busy}, 64'b101);
        check("dz hi/lo kept", {hi, lo}, {curHi, curLo});
        @(posedge clk);
        #1;
        check("dz back to idle", {61'd0, div_zero, done, busy}, 64'd0);
        check("dz hi/lo still kept", {hi, lo}, {curHi, curLo});
`endif

        for (int i = 0; i < 24; i++) begin
            bit          m = 1'($urandom_range(0, 1));
            logic [31:0] a = $urandom;
            logic [31:0] b = (i % 4 == 1) ? 32'($urandom_range(0, 9)) : $urandom;
`ifdef DIVZERO_EXCP_EN
            if (b == '0) b = 32'd3;
`endif
            runOp($sformatf("rnd%0d", i), m, 1'b0, a, b, (i % 3 == 0),
                  refResult(m, a, b), m ? 33 : 34);
        end

        // Reset mid-multiply with a div_start pulse that must be ignored.
        begin
            bit sawDone = 1'b0;
            @(negedge clk);
            mult_start = 1'b1;
            op_a = 32'd9;
            op_b = 32'd9;
            @(posedge clk);
            #1;
            mult_start = 1'b0;
            for (int n = 0; n < 10; n++) begin
                div_start = (n == 4);
                @(posedge clk);
                #1;
            end
            div_start = 1'b0;
            check("pre-reset busy", {62'd0, busy, done}, 64'b10);
            reset = 1'b1;
            #1;
            check("reset async hi/lo", {hi, lo}, 64'd0);
            check("reset async flags", {61'd0, busy, done, div_zero}, 64'd0);
            @(posedge clk);
            #1;
            check("reset held flags", {61'd0, busy, done, div_zero}, 64'd0);
            @(negedge clk);
            reset = 1'b0;
            curHi = '0;
            curLo = '0;
            for (int n = 0; n < 40; n++) begin
                @(posedge clk);
                #1;
                if (done || busy) sawDone = 1'b1;
            end
            check("no done after reset", 64'(sawDone), 64'd0);
            runOp("post-reset mult", 1'b1, 1'b0, 32'd3, 32'd4, 1'b0, {32'd0, 32'd12}, 33);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; both are listed below.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 mult_start  input  1  one-cycle request for signed multiply (MIPS mult).
REQ-005 div_start  input  1  one-cycle request for signed divide (MIPS div).
REQ-006 op_a  input  32  first operand (rs); multiplicand or dividend, two's complement.
REQ-007 op_b  input  32  second operand (rt); multiplier or divisor, two's complement.
REQ-008 hi  output  32  upper product word or remainder; feeds the HI register write path.
REQ-009 lo  output  32  lower product word or quotient; feeds the LO register write path.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse; hi/lo hold the new result in that cycle.
REQ-012 div_zero  output  1  one-cycle divide-by-zero pulse to the exception logic.

Function
REQ-013 The FSM SHALL have states IDLE, MULT, DIV, FIX, DZ and DONE.
REQ-014 In IDLE, a start SHALL latch op_a and op_b on that edge; later operand changes SHALL have no effect.
REQ-015 When mult_start and div_start are both high in IDLE, the multiply SHALL win.
REQ-016 A start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-017 MULT SHALL run radix-2 Booth, one iteration per cycle, 32 iterations, using a 6-bit counter.
REQ-018 The multiply SHALL produce {hi,lo} = full 64-bit signed product of op_a and op_b.
REQ-019 DIV SHALL run restoring division on operand magnitudes, 32 iterations, one per cycle.
REQ-020 FIX (1 cycle) SHALL apply signs:
  - quotient truncates toward zero;
  - remainder takes the dividend's sign;
  - lo = quotient, hi = remainder.
REQ-021 For 0x80000000 / 0xFFFFFFFF the result SHALL be lo = 0x80000000, hi = 0, with no flag.
REQ-022 Latency: start sampled at edge 0.
  - Multiply: done is high in the cycle after edge 33.
  - Divide: done is high in the cycle after edge 34.
REQ-023 hi and lo SHALL keep their previous values during operation and SHALL update only on entry to DONE.
REQ-024 hi and lo SHALL then hold until the next completed operation.
REQ-025 DONE SHALL last exactly one cycle and then return to IDLE, so a new start is accepted in the DONE+1 cycle.
REQ-026 The DONE-cycle value of busy SHALL be 1.

Reset
REQ-027 While reset is asserted, outputs SHALL immediately be hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0.
REQ-028 While reset is asserted, the state SHALL be IDLE and the counter SHALL be 0.
REQ-029 Reset during MULT, DIV or FIX SHALL abort the operation; no done SHALL follow.
REQ-030 After reset is released, the block SHALL be ready for a start.

Configuration
REQ-031 Macro DIVZERO_EXCP_EN, when defined:
  - a div_start with op_b = 0 SHALL go to DZ for one cycle;
  - div_zero SHALL pulse in that cycle;
  - done SHALL NOT pulse and hi/lo SHALL be unchanged;
  - the block SHALL then return to IDLE.
REQ-032 Macro DIVZERO_EXCP_EN, when undefined:
  - DZ SHALL be absent and div_zero SHALL be tied 0;
  - divide by zero SHALL complete with normal divide latency;
  - the result SHALL be lo = 0xFFFFFFFF, hi = op_a.

Verification
REQ-033 mult op_a = 7, op_b = 0xFFFFFFFD -> done 33 cycles later, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy high for 33 cycles.
REQ-034 mult 0x80000000 x 0x80000000 -> hi = 0x40000000, lo = 0x00000000.
REQ-035 div 0xFFFFFFF9 / 2 -> done 34 cycles later, lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-036 div 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-037 div 5 / 0 -> with DIVZERO_EXCP_EN, div_zero for 1 cycle, no done, hi/lo unchanged; without it, done at 34, lo = 0xFFFFFFFF, hi = 5.
REQ-038 Start mult, pulse div_start at cycle 5, assert reset at cycle 10:
  - div_start is ignored;
  - all outputs are 0 during reset, with no done afterwards;
  - the next mult 3 x 4 gives lo = 12, hi = 0.
